// File: rtl/rot_arbiter_pkg.sv
// Shared types and sizes for the two-port rotate arbiter.
package rot_arbiter_pkg;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    RESP = 2'b10
  } state_t;

  // Operand captured at grant time; dir lives outside so the right-only build has no unused bits.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
    logic              id;
  } op_t;
endpackage

// File: rtl/rot_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port named by prio.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | ~prio);
  assign gnt[1] = req[1] & (~req[0] |  prio);
endmodule

// File: rtl/rot_arbiter.sv
// Two-requester rotate unit: round-robin grant, one rotate per 2 cycles, held response.
// Define ROT_ARBITER_LEFT_EN to honour dirN_i (left rotate); otherwise everything rotates right.
module rot_arbiter
  import rot_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [DATA_W-1:0] in0_i,
  input  logic [DATA_W-1:0] in1_i,
  input  logic [CNT_W-1:0]  cnt0_i,
  input  logic [CNT_W-1:0]  cnt1_i,
  input  logic              dir0_i,
  input  logic              dir1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_id_o,
  input  logic              rsp_ready_i
);
  state_t            state, state_nxt;
  logic              prio;
  op_t               op;
  logic [1:0]        req, pick, gnt;
  logic [CNT_W-1:0]  sh;
  logic [DATA_W-1:0] rot;

  assign req = {req1_i, req0_i};

  rr_pick2 u_pick (
    .req  (req),
    .prio (prio),
    .gnt  (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grants are only legal in IDLE or when the held response is being consumed.
  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    case (state)
      IDLE: begin
        gnt = pick;
        if (|req) state_nxt = CALC;
      end
      CALC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready_i) begin
          gnt       = pick;
          state_nxt = (|req) ? CALC : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) gnt = 2'b00;
  end

  assign gnt0_o = gnt[0];
  assign gnt1_o = gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op   <= '0;
      prio <= 1'b0;
    end else if (|gnt) begin
      op.id   <= gnt[1];
      op.data <= gnt[1] ? in1_i  : in0_i;
      op.cnt  <= gnt[1] ? cnt1_i : cnt0_i;
      prio    <= gnt[0];
    end
  end

`ifdef ROT_ARBITER_LEFT_EN
  logic op_dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     op_dir <= 1'b0;
    else if (|gnt)  op_dir <= gnt[1] ? dir1_i : dir0_i;
  end

  // Left by c is right by (16-c) mod 16, i.e. the two's complement of c.
  assign sh = op_dir ? (CNT_W'(0) - op.cnt) : op.cnt;
`else
  logic unused_dir;
  assign unused_dir = dir0_i ^ dir1_i;
  assign sh = op.cnt;
`endif

  // Log shifter: stages rotate right by 8/4/2/1.
  always_comb begin
    rot = op.data;
    for (int k = CNT_W-1; k >= 0; k--) begin
      if (sh[k]) rot = (rot >> (1 << k)) | (rot << (DATA_W - (1 << k)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_id_o    <= 1'b0;
    end else if (state == CALC) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= rot;
      rsp_id_o    <= op.id;
    end else if (state == RESP && rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rot_arbiter.sv
// Directed bench for rot_arbiter; expected results are hand-computed rotations.
module tb_rot_arbiter;
  logic        clk, rst_n;
  logic        req0, req1, dir0, dir1, rsp_ready;
  logic [15:0] in0, in1;
  logic [3:0]  cnt0, cnt1;
  logic        gnt0, gnt1, rsp_valid, rsp_id;
  logic [15:0] rsp_data;

  int n_tot = 0;
  int n_bad = 0;

`ifdef ROT_ARBITER_LEFT_EN
  localparam logic [15:0] EXP_L = 16'h0003;
`else
  localparam logic [15:0] EXP_L = 16'hC000;
`endif

  logic [15:0] rr_d [4] = '{16'h1234, 16'h00FF, 16'h0001, 16'hF000};
  logic [3:0]  rr_c [4] = '{4'd4, 4'd8, 4'd1, 4'd12};
  logic [15:0] rr_e [4] = '{16'h4123, 16'hFF00, 16'h8000, 16'h000F};

  rot_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_i      (req0),
    .req1_i      (req1),
    .in0_i       (in0),
    .in1_i       (in1),
    .cnt0_i      (cnt0),
    .cnt1_i      (cnt1),
    .dir0_i      (dir0),
    .dir1_i      (dir1),
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .rsp_ready_i (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit p, input bit v, input logic [15:0] d, input logic [3:0] c, input bit dr);
    if (!p) begin req0 = v; in0 = d; cnt0 = c; dir0 = dr; end
    else    begin req1 = v; in1 = d; cnt1 = c; dir1 = dr; end
  endtask

  // Lone request from port p, full grant -> calc -> response -> accept round trip.
  task automatic do_op(input string tag, input bit p, input logic [15:0] d, input logic [3:0] c,
                       input bit dr, input logic [15:0] exp);
    @(negedge clk);
    drive(p, 1'b1, d, c, dr);
    #1 chk({tag, "_gnt"}, 32'({gnt1, gnt0}), 32'(p ? 2'b10 : 2'b01));
    @(negedge clk);
    drive(p, 1'b0, d, c, dr);
    #1 chk({tag, "_calc"}, 32'({rsp_valid, gnt1, gnt0}), 32'(3'b000));
    @(negedge clk);
    chk({tag, "_vld"},  32'(rsp_valid), 32'(1'b1));
    chk({tag, "_data"}, 32'(rsp_data),  32'(exp));
    chk({tag, "_id"},   32'(rsp_id),    32'(p));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_clr"}, 32'(rsp_valid), 32'(1'b0));
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    @(negedge clk);
    req0 = 1'b1;
    #1;
    chk("rst_out", 32'({rsp_valid, rsp_id, gnt1, gnt0}), 32'(4'b0000));
    chk("rst_data", 32'(rsp_data), 32'(16'h0000));
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesting back-to-back: grants alternate 0,1,0,1 starting with port 0.
    rsp_ready = 1'b1;
    drive(1'b0, 1'b1, rr_d[0], rr_c[0], 1'b0);
    drive(1'b1, 1'b1, rr_d[1], rr_c[1], 1'b0);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d_gnt", k), 32'({gnt1, gnt0}), 32'((k % 2) ? 2'b10 : 2'b01));
      @(negedge clk);
      if (k + 2 < 4) drive(1'(k % 2), 1'b1, rr_d[k+2], rr_c[k+2], 1'b0);
      else           drive(1'(k % 2), 1'b0, 16'h0, 4'h0, 1'b0);
      #1 chk($sformatf("rr%0d_calc", k), 32'({rsp_valid, gnt1, gnt0}), 32'(3'b000));
      @(negedge clk);
      chk($sformatf("rr%0d_vld", k),  32'(rsp_valid), 32'(1'b1));
      chk($sformatf("rr%0d_data", k), 32'(rsp_data),  32'(rr_e[k]));
      chk($sformatf("rr%0d_id", k),   32'(rsp_id),    32'(k % 2));
      #1;
    end
    chk("rr_nognt", 32'({gnt1, gnt0}), 32'(2'b00));
    @(negedge clk);
    chk("rr_clr", 32'(rsp_valid), 32'(1'b0));
    rsp_ready = 1'b0;

    do_op("basic", 1'b0, 16'h2028, 4'd5, 1'b0, 16'h4101);
    do_op("left",  1'b1, 16'h8001, 4'd1, 1'b1, EXP_L);
    do_op("z0",    1'b0, 16'hBEEF, 4'd0, 1'b0, 16'hBEEF);
    do_op("z1",    1'b1, 16'hBEEF, 4'd0, 1'b1, 16'hBEEF);

    // Stall: response held with ready low, pending req1 granted the cycle ready rises.
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h2028, 4'd5, 1'b0);
    #1 chk("stl_gnt0", 32'({gnt1, gnt0}), 32'(2'b01));
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 16'h00F0, 4'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stl%0d_hold", i), 32'({rsp_valid, rsp_id, gnt1, gnt0}), 32'(4'b1000));
      chk($sformatf("stl%0d_data", i), 32'(rsp_data), 32'(16'h4101));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 chk("stl_gnt1", 32'({gnt1, gnt0}), 32'(2'b10));
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    rsp_ready = 1'b0;
    #1 chk("stl_clr", 32'(rsp_valid), 32'(1'b0));
    @(negedge clk);
    chk("stl2_data", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 1'b1, 16'h000F}));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stl2_clr", 32'(rsp_valid), 32'(1'b0));
    rsp_ready = 1'b0;

    // Reset in CALC: no response, and prio goes back to port 0.
    do_op("pre", 1'b0, 16'h0010, 4'd4, 1'b0, 16'h0001);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0F0F, 4'd4, 1'b0);
    #1 chk("mr_gnt", 32'({gnt1, gnt0}), 32'(2'b01));
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    rst_n = 1'b0;
    #1 chk("mr_rst", 32'({rsp_valid, gnt1, gnt0}), 32'(3'b000));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("mr_norsp%0d", i), 32'(rsp_valid), 32'(1'b0));
    end
    drive(1'b0, 1'b1, 16'h0003, 4'd1, 1'b0);
    drive(1'b1, 1'b1, 16'h1111, 4'd1, 1'b0);
    #1 chk("mr_prio", 32'({gnt1, gnt0}), 32'(2'b01));
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk("mr_data", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 1'b0, 16'h8001}));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mr_clr", 32'(rsp_valid), 32'(1'b0));
    rsp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
